// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, issues in-order instruction reads, epoch-tags them and buffers returns.
// Optional branch prediction is enabled by defining FETCH_BRANCH_PRED_EN.
`timescale 1ns/1ps
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ImemReqF,
    output logic [31:0] ImemAddrF,
    input  logic        ImemReadyF,
    input  logic        ImemRspValidF,
    input  logic [31:0] ImemRdataF,
    input  logic        PredTakenF,
    input  logic [31:0] PredTargetF,
    input  logic        RedirectE,
    input  logic [31:0] RedirectPCE,
    input  logic        StallD,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic [31:0] PredPCTargetF,
    output logic        PCSrcPredF,
    output logic        InstrValidF
);
    localparam int              AW        = $clog2(DEPTH);
    localparam int              CW        = AW + 2;
    localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]   CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0]   CNT_DEPTH = CW'(DEPTH);
    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;

    logic [31:0]   pc_q, pc_d;
    logic          epoch_q, epoch_d;
    logic [AW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [CW-1:0] tag_cnt_q, tag_cnt_d;
    logic [AW-1:0] ib_wr_q, ib_wr_d, ib_rd_q, ib_rd_d;
    logic [CW-1:0] ib_cnt_q, ib_cnt_d;

    logic [31:0] tag_pc_q    [DEPTH];
    logic [31:0] tag_pnext_q [DEPTH];
    logic        tag_taken_q [DEPTH];
    logic        tag_epoch_q [DEPTH];
    logic [31:0] ib_instr_q  [DEPTH];
    logic [31:0] ib_pc_q     [DEPTH];
    logic [31:0] ib_pc4_q    [DEPTH];
    logic [31:0] ib_pnext_q  [DEPTH];
    logic        ib_taken_q  [DEPTH];

    logic          pop_s, accept_s, rsp_take_s, ib_push_s;
    logic          pred_taken_s;
    logic [31:0]   pc_plus4_s, pred_next_s;
    logic [CW-1:0] credit_used_s;

    assign pc_plus4_s = pc_q + 32'd4;

`ifdef FETCH_BRANCH_PRED_EN
    assign pred_taken_s = PredTakenF;
    assign pred_next_s  = PredTakenF ? PredTargetF : pc_plus4_s;
`else
    logic unused_pred_s;
    assign unused_pred_s = ^{PredTakenF, PredTargetF};
    assign pred_taken_s  = 1'b0;
    assign pred_next_s   = pc_plus4_s;
`endif

    assign ImemAddrF   = pc_q;
    assign InstrValidF = (ib_cnt_q != CNT_ZERO);
    assign pop_s       = InstrValidF & ~StallD;
    // Stale in-flight tags still hold credit, so the buffer can never overflow.
    assign credit_used_s = tag_cnt_q + ib_cnt_q - {{(CW-1){1'b0}}, pop_s};
    assign ImemReqF      = ~reset & ~RedirectE & (credit_used_s < CNT_DEPTH);
    assign accept_s      = ImemReqF & ImemReadyF;
    assign rsp_take_s    = ImemRspValidF & (tag_cnt_q != CNT_ZERO);
    assign ib_push_s     = rsp_take_s & (tag_epoch_q[tag_rd_q] == epoch_q) & ~RedirectE;

    // Next-state for PC, epoch and both FIFO pointer/count sets.
    always_comb begin
        pc_d    = pc_q;
        epoch_d = epoch_q;
        if (RedirectE) begin
            pc_d    = RedirectPCE;
            epoch_d = ~epoch_q;
        end else if (accept_s) begin
            pc_d = pred_next_s;
        end else begin
            pc_d = pc_q;
        end

        tag_wr_d = accept_s   ? (tag_wr_q + PTR_ONE) : tag_wr_q;
        tag_rd_d = rsp_take_s ? (tag_rd_q + PTR_ONE) : tag_rd_q;
        case ({accept_s, rsp_take_s})
            2'b10:   tag_cnt_d = tag_cnt_q + CNT_ONE;
            2'b01:   tag_cnt_d = tag_cnt_q - CNT_ONE;
            default: tag_cnt_d = tag_cnt_q;
        endcase

        if (RedirectE) begin
            ib_wr_d  = {AW{1'b0}};
            ib_rd_d  = {AW{1'b0}};
            ib_cnt_d = CNT_ZERO;
        end else begin
            ib_wr_d = ib_push_s ? (ib_wr_q + PTR_ONE) : ib_wr_q;
            ib_rd_d = pop_s     ? (ib_rd_q + PTR_ONE) : ib_rd_q;
            case ({ib_push_s, pop_s})
                2'b10:   ib_cnt_d = ib_cnt_q + CNT_ONE;
                2'b01:   ib_cnt_d = ib_cnt_q - CNT_ONE;
                default: ib_cnt_d = ib_cnt_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            epoch_q   <= 1'b0;
            tag_wr_q  <= {AW{1'b0}};
            tag_rd_q  <= {AW{1'b0}};
            tag_cnt_q <= CNT_ZERO;
            ib_wr_q   <= {AW{1'b0}};
            ib_rd_q   <= {AW{1'b0}};
            ib_cnt_q  <= CNT_ZERO;
        end else begin
            pc_q      <= pc_d;
            epoch_q   <= epoch_d;
            tag_wr_q  <= tag_wr_d;
            tag_rd_q  <= tag_rd_d;
            tag_cnt_q <= tag_cnt_d;
            ib_wr_q   <= ib_wr_d;
            ib_rd_q   <= ib_rd_d;
            ib_cnt_q  <= ib_cnt_d;
        end
    end

    // FIFO payload storage; validity is tracked solely by the counters.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            tag_pc_q[tag_wr_q]    <= pc_q;
            tag_pnext_q[tag_wr_q] <= pred_next_s;
            tag_taken_q[tag_wr_q] <= pred_taken_s;
            tag_epoch_q[tag_wr_q] <= epoch_q;
        end
        if (ib_push_s) begin
            ib_instr_q[ib_wr_q] <= ImemRdataF;
            ib_pc_q[ib_wr_q]    <= tag_pc_q[tag_rd_q];
            ib_pc4_q[ib_wr_q]   <= tag_pc_q[tag_rd_q] + 32'd4;
            ib_pnext_q[ib_wr_q] <= tag_pnext_q[tag_rd_q];
            ib_taken_q[ib_wr_q] <= tag_taken_q[tag_rd_q];
        end
    end

    // Head-of-buffer presentation to decode.
    always_comb begin
        if (InstrValidF) begin
            InstrF        = ib_instr_q[ib_rd_q];
            PCF           = ib_pc_q[ib_rd_q];
            PCPlus4F      = ib_pc4_q[ib_rd_q];
            PredPCTargetF = ib_pnext_q[ib_rd_q];
            PCSrcPredF    = ib_taken_q[ib_rd_q];
        end else begin
            InstrF        = NOP_INSTR;
            PCF           = 32'h0000_0000;
            PCPlus4F      = 32'h0000_0000;
            PredPCTargetF = 32'h0000_0000;
            PCSrcPredF    = 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage: an in-bench memory model with 1- or 2-cycle latency,
// expected request addresses and expected pops held in queues.
`timescale 1ns/1ps
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        ImemReqF, ImemReadyF, ImemRspValidF;
    logic [31:0] ImemAddrF, ImemRdataF;
    logic        PredTakenF, RedirectE, StallD;
    logic [31:0] PredTargetF, RedirectPCE;
    logic [31:0] InstrF, PCF, PCPlus4F, PredPCTargetF;
    logic        PCSrcPredF, InstrValidF;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_1000), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .ImemReqF(ImemReqF), .ImemAddrF(ImemAddrF), .ImemReadyF(ImemReadyF),
        .ImemRspValidF(ImemRspValidF), .ImemRdataF(ImemRdataF),
        .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
        .RedirectE(RedirectE), .RedirectPCE(RedirectPCE), .StallD(StallD),
        .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
        .PredPCTargetF(PredPCTargetF), .PCSrcPredF(PCSrcPredF), .InstrValidF(InstrValidF)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pnext;
        logic        taken;
    } ent_t;

    logic [31:0] req_q[$];
    ent_t        pop_q[$];
    int          tests = 0;
    int          fails = 0;
    int          pops_seen = 0;
    int          base = 0;
    int          mem_lat = 1;
    logic        pred_arm = 1'b0;
    logic        d1_v = 1'b0;
    logic [31:0] d1_a = 32'h0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic fill_req(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) req_q.push_back(start + 32'(4 * i));
    endtask

    // One clock cycle: predictor lookup, pop/request scoreboarding, then memory response update.
    task automatic tick();
        ent_t        e;
        logic        acc;
        logic [31:0] a, want;
        #1;
        PredTakenF  = pred_arm && (ImemAddrF == 32'h0000_1004);
        PredTargetF = 32'h0000_3000;
        #1;
        if (InstrValidF && !StallD && !RedirectE) begin
            pops_seen++;
            if (pop_q.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL pop_extra: observed pop of PC %h, expected no pop", PCF);
            end else begin
                e = pop_q.pop_front();
                chk("pop_pc", PCF, e.pc);
                chk("pop_instr", InstrF, instr_of(e.pc));
                chk("pop_pc4", PCPlus4F, e.pc + 32'd4);
                chk("pop_pnext", PredPCTargetF, e.pnext);
                chk("pop_taken", {31'h0, PCSrcPredF}, {31'h0, e.taken});
            end
        end
        acc = ImemReqF && ImemReadyF;
        a   = ImemAddrF;
        if (acc) begin
            if (req_q.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL req_extra: observed request %h, expected none", a);
            end else begin
                want = req_q.pop_front();
                chk("req_addr", a, want);
`ifdef FETCH_BRANCH_PRED_EN
                e.taken = pred_arm && (want == 32'h0000_1004);
`else
                e.taken = 1'b0;
`endif
                e.pc    = want;
                e.pnext = e.taken ? 32'h0000_3000 : want + 32'd4;
                pop_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        if (reset) begin
            ImemRspValidF = 1'b0;
            d1_v          = 1'b0;
        end else if (mem_lat == 1) begin
            ImemRspValidF = acc;
            ImemRdataF    = instr_of(a);
        end else begin
            ImemRspValidF = d1_v;
            ImemRdataF    = instr_of(d1_a);
            d1_v          = acc;
            d1_a          = a;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        StallD     = 1'b0;
        RedirectE  = 1'b0;
        ImemReadyF = 1'b1;
        tick();
        tick();
        req_q.delete();
        pop_q.delete();
        fill_req(32'h0000_1000, 40);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ImemReadyF = 1'b1; ImemRspValidF = 1'b0; ImemRdataF = 32'h0;
        PredTakenF = 1'b0; PredTargetF = 32'h0; RedirectE = 1'b0; RedirectPCE = 32'h0; StallD = 1'b0;
        @(negedge clk);
        #2;
        chk("rst_req", {31'h0, ImemReqF}, 32'h0);
        chk("rst_valid", {31'h0, InstrValidF}, 32'h0);
        chk("rst_instr", InstrF, 32'h0000_0013);
        chk("rst_pc", PCF, 32'h0);
        chk("rst_pc4", PCPlus4F, 32'h0);
        chk("rst_pnext", PredPCTargetF, 32'h0);
        chk("rst_taken", {31'h0, PCSrcPredF}, 32'h0);
        chk("rst_addr", ImemAddrF, 32'h0000_1000);
        do_reset();

        // Streaming from reset, then a 6-cycle decode stall.
        for (int c = 0; c < 6; c++) begin
            if (c < 3) chk("first_valid_timing", {31'h0, InstrValidF}, (c == 2) ? 32'h1 : 32'h0);
            tick();
        end
        StallD = 1'b1;
        for (int c = 6; c < 12; c++) begin
            #2;
            if (c == 7) chk("stall_req_credit", {31'h0, ImemReqF}, 32'h1);
            if (c == 8 || c == 11) chk("stall_req_full", {31'h0, ImemReqF}, 32'h0);
            tick();
        end
        StallD = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        chk("stall_pop_count", 32'(pops_seen), 32'd12);

        // Memory not ready for 3 cycles.
        do_reset();
        base = pops_seen;
        tick();
        tick();
        ImemReadyF = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk("nrdy_addr", ImemAddrF, 32'h0000_1008);
            chk("nrdy_req", {31'h0, ImemReqF}, 32'h1);
            tick();
        end
        ImemReadyF = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        chk("nrdy_pop_count", 32'(pops_seen - base), 32'd6);

        // Predicted-taken at 0x1004.
        do_reset();
        pred_arm = 1'b1;
`ifdef FETCH_BRANCH_PRED_EN
        req_q.delete();
        fill_req(32'h0000_1000, 2);
        fill_req(32'h0000_3000, 40);
`endif
        tick();
        tick();
        #2;
`ifdef FETCH_BRANCH_PRED_EN
        chk("pred_next_addr", ImemAddrF, 32'h0000_3000);
`else
        chk("pred_next_addr", ImemAddrF, 32'h0000_1008);
`endif
        for (int c = 0; c < 4; c++) tick();
        pred_arm = 1'b0;

        // Redirect with two fetches in flight (2-cycle memory latency).
        do_reset();
        mem_lat = 2;
        for (int c = 0; c < 4; c++) tick();
        RedirectE   = 1'b1;
        RedirectPCE = 32'h0000_2000;
        #2;
        chk("redir_req_low", {31'h0, ImemReqF}, 32'h0);
        tick();
        RedirectE = 1'b0;
        req_q.delete();
        pop_q.delete();
        fill_req(32'h0000_2000, 40);
        #2;
        chk("redir_addr", ImemAddrF, 32'h0000_2000);
        chk("redir_req", {31'h0, ImemReqF}, 32'h1);
        chk("redir_flush", {31'h0, InstrValidF}, 32'h0);
        base = pops_seen;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("redir_valid_timing", {31'h0, InstrValidF}, (c == 2) ? 32'h1 : 32'h0);
        end
        for (int c = 0; c < 4; c++) tick();
        chk("redir_pop_count", 32'(pops_seen - base), 32'd4);
        mem_lat = 1;

        // Reset asserted with three instructions buffered.
        do_reset();
        StallD = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        chk("pre_rst_valid", {31'h0, InstrValidF}, 32'h1);
        reset = 1'b1;
        #1;
        chk("midrst_valid", {31'h0, InstrValidF}, 32'h0);
        chk("midrst_req", {31'h0, ImemReqF}, 32'h0);
        chk("midrst_instr", InstrF, 32'h0000_0013);
        chk("midrst_pc", PCF, 32'h0);
        chk("midrst_addr", ImemAddrF, 32'h0000_1000);
        do_reset();
        base = pops_seen;
        for (int c = 0; c < 4; c++) tick();
        chk("refetch_pop_count", 32'(pops_seen - base), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
